layer_input_feeder: RTL and testbench
=====================================

LAYER_INPUT_FEEDER -- requirements
Module: layer_input_feeder

Interface
REQ-001 Parameter N_INPUTS, default 3: words delivered per layer pass (2..255).
REQ-002 Parameter DATA_W, default 8: activation word width.
REQ-003 Parameter TIMEOUT, default 15: maximum cycles to wait for ack__mac (1..255).
REQ-004 clk  in  1  single clock; all state updates on the falling edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  request to begin one layer pass; sampled only in IDLE.
REQ-007 in_valid  in  1  upstream word available.
REQ-008 in_data  in  DATA_W  upstream activation word.
REQ-009 in_ready  out  1  feeder accepts a word this cycle.
REQ-010 x_data  out  DATA_W  registered word presented to the layer.
REQ-011 ack  out  1  one-cycle strobe: x_data is valid, and the layer counter increments.
REQ-012 clr  out  1  one-cycle strobe clearing the layer counter at pass start.
REQ-013 ack__mac  in  1  level from the layer counter: all words accumulated.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 done  out  1  one-cycle strobe: pass completed normally.
REQ-016 err  out  1  sticky flag: ack__mac timed out; cleared by start or rst.

Function
REQ-017 The FSM shall have the states IDLE, CLEAR, FEED, WAIT_MAC and FINISH.
REQ-018 IDLE: in_ready=0; start=1 shall go to CLEAR, zero word count cnt, and clear err.
REQ-019 CLEAR shall last exactly one cycle with clr=1, then go to FEED.
REQ-020 FEED: in_ready=1; a transfer occurs on a falling edge with in_valid=1 and in_ready=1.
REQ-021 Each transfer shall register x_data<=in_data, pulse ack for the next cycle only, and increment cnt.
REQ-022 A transfer with cnt==N_INPUTS-1 shall move to WAIT_MAC, and in_ready shall be 0 from the next cycle.
REQ-023 in_valid=0 in FEED shall hold state, cnt and x_data, with ack=0.
REQ-024 WAIT_MAC shall load wdog=0 on entry and increment it each cycle while ack__mac=0.
REQ-025 ack__mac=1 in WAIT_MAC shall move to FINISH.
REQ-026 If wdog reaches TIMEOUT with ack__mac still 0, the FSM shall set err=1 and go to IDLE with no done.
REQ-027 If ack__mac=1 and wdog==TIMEOUT in the same cycle, success shall win and the FSM shall go to FINISH.
REQ-028 FINISH shall pulse done for one cycle, then go to IDLE.
REQ-029 ack__mac=1 outside WAIT_MAC shall be ignored.
REQ-030 start outside IDLE shall be ignored; start in FINISH shall not be queued.
REQ-031 cnt and wdog shall be 8-bit and shall never wrap within legal parameter ranges.
REQ-032 x_data shall retain the last delivered word until the next transfer.
REQ-033 ack, clr and done shall never be high for two consecutive cycles.

Reset
REQ-034 rst=1 shall immediately force state=IDLE, cnt=0, wdog=0, x_data=0, and in_ready=ack=clr=busy=done=err=0.
REQ-035 rst asserted mid-pass shall abandon the pass without a done or err strobe.
REQ-036 After rst deasserts, the block shall wait in IDLE for start.

Verification
REQ-037 Normal pass, defaults: start; in_valid held 1 with words 0x11, 0x22, 0x33; counter model raises ack__mac after the third ack -> clr once, three ack strobes with x_data 0x11/0x22/0x33, then done=1 for one cycle, busy=0, err=0.
REQ-038 Bubbles: in_valid toggles 1,0,0,1,0,1 -> exactly three acks, cnt holds through gaps, in_ready=0 after the third transfer.
REQ-039 Timeout: ack__mac held 0 after the third word -> err=1 after 15 WAIT_MAC cycles, no done, IDLE; the next start clears err.
REQ-040 Race: ack__mac rises in the same cycle wdog==TIMEOUT -> done=1, err=0.
REQ-041 Mid-pass reset: rst asserted after the second ack -> all outputs 0 at once; a new start yields clr and a full three-word pass.
REQ-042 Spurious inputs: start pulsed during FEED and ack__mac pulsed during FEED -> no state change, no extra clr, exactly N_INPUTS acks.

Source files
------------

// File: rtl/layer_input_feeder.sv
// Feeds N_INPUTS activation words to a layer, then waits (with a watchdog)
// for the layer counter to report that every word has been accumulated.
module layer_input_feeder #(
   parameter int N_INPUTS = 3,
   parameter int DATA_W   = 8,
   parameter int TIMEOUT  = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [DATA_W-1:0] x_data,
   output logic              ack,
   output logic              clr,
   input  logic              ack__mac,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      WAIT_MAC,
      FINISH
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(N_INPUTS - 1);
   localparam logic [7:0] WDOG_MAX = 8'(TIMEOUT);

   state_t     r_state;
   logic [7:0] r_cnt;
   logic [7:0] r_wdog;
   logic       w_xfer;

   assign w_xfer = in_valid && in_ready;

   // Every state register and every output changes on the falling edge.
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cnt    <= 8'd0;
         r_wdog   <= 8'd0;
         x_data   <= '0;
         in_ready <= 1'b0;
         ack      <= 1'b0;
         clr      <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         ack  <= 1'b0;
         clr  <= 1'b0;
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               in_ready <= 1'b0;
               if (start) begin
                  r_state <= CLEAR;
                  r_cnt   <= 8'd0;
                  err     <= 1'b0;
                  clr     <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            CLEAR: begin
               r_state  <= FEED;
               in_ready <= 1'b1;
            end
            FEED: begin
               if (w_xfer) begin
                  x_data <= in_data;
                  ack    <= 1'b1;
                  r_cnt  <= r_cnt + 8'd1;
                  if (r_cnt == LAST_IDX) begin
                     r_state  <= WAIT_MAC;
                     r_wdog   <= 8'd0;
                     in_ready <= 1'b0;
                  end
               end
            end
            WAIT_MAC: begin
               // A completion arriving together with the timeout still counts as success.
               if (ack__mac) begin
                  r_state <= FINISH;
                  done    <= 1'b1;
               end else if (r_wdog == WDOG_MAX) begin
                  r_state <= IDLE;
                  err     <= 1'b1;
                  busy    <= 1'b0;
               end else begin
                  r_wdog <= r_wdog + 8'd1;
               end
            end
            FINISH: begin
               r_state <= IDLE;
               busy    <= 1'b0;
            end
            default: begin
               r_state  <= IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_layer_input_feeder.sv
// Directed bench for layer_input_feeder: a small layer-counter model supplies
// ack__mac, or the bench forces it to exercise timeout and race cases.
module tb_layer_input_feeder;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic [7:0] x_data;
   logic       ack;
   logic       clr;
   logic       ack__mac;
   logic       busy;
   logic       done;
   logic       err;

   logic       use_model;
   logic       mac_force;
   logic       spur_mac;
   logic [7:0] m_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   layer_input_feeder #(.N_INPUTS(3), .DATA_W(8), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .x_data(x_data), .ack(ack), .clr(clr), .ack__mac(ack__mac),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Layer counter model: cleared by clr, counts ack strobes.
   always @(negedge clk or posedge rst) begin
      if (rst)      m_cnt <= 8'd0;
      else if (clr) m_cnt <= 8'd0;
      else if (ack) m_cnt <= m_cnt + 8'd1;
   end

   assign ack__mac = (use_model ? (m_cnt == 8'd3) : mac_force) | spur_mac;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_outs"}, {in_ready, ack, clr, busy, done, err}, 6'b0);
      check({tag, "_xdata"}, x_data, 8'h00);
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      check("start_clr", clr, 1'b1);
      check("start_busy", busy, 1'b1);
      check("start_err_clear", err, 1'b0);
      check("start_rdy", in_ready, 1'b0);
      start = 1'b0;
      step();
      check("clear_clr_low", clr, 1'b0);
      check("feed_rdy", in_ready, 1'b1);
   endtask

   task automatic feed(input logic [7:0] vpat, input int len, input logic [7:0] w0,
                       input logic [7:0] w1, input logic [7:0] w2, input bit spur);
      logic [7:0] words [3];
      int widx  = 0;
      int n_ack = 0;
      int n_exp = 0;
      words[0] = w0; words[1] = w1; words[2] = w2;
      for (int i = 0; i < len; i++) begin
         in_valid = vpat[i];
         in_data  = vpat[i] ? words[widx] : 8'hEE;
         if (spur && i == 1) begin
            start    = 1'b1;
            spur_mac = 1'b1;
         end
         step();
         start    = 1'b0;
         spur_mac = 1'b0;
         n_ack += int'(ack);
         check("feed_clr_low", clr, 1'b0);
         if (vpat[i]) begin
            n_exp++;
            check("feed_ack", ack, 1'b1);
            check("feed_xdata", x_data, words[widx]);
            widx++;
         end else begin
            check("gap_ack", ack, 1'b0);
            if (widx > 0) check("gap_hold_xdata", x_data, words[widx-1]);
         end
         check("feed_rdy", in_ready, (widx < 3) ? 1'b1 : 1'b0);
      end
      in_valid = 1'b0;
      check("ack_count", n_ack, n_exp);
   endtask

   task automatic wait_done();
      int k = 0;
      while (!done && !err && k < 40) begin
         step();
         k++;
      end
      check("pass_done", done, 1'b1);
      check("pass_err", err, 1'b0);
      step();
      check("done_one_cycle", done, 1'b0);
      check("end_busy", busy, 1'b0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      use_model = 1'b1; mac_force = 1'b0; spur_mac = 1'b0;
      step(); step();
      check_all_zero("reset");
      rst = 1'b0;
      step();
      check("idle_wait_busy", busy, 1'b0);

      // Normal pass
      do_start();
      feed(8'b0000_0111, 3, 8'h11, 8'h22, 8'h33, 1'b0);
      wait_done();

      // Bubbles 1,0,0,1,0,1
      do_start();
      feed(8'b0010_1001, 6, 8'hA1, 8'hB2, 8'hC3, 1'b0);
      wait_done();

      // Timeout
      use_model = 1'b0;
      do_start();
      feed(8'b0000_0111, 3, 8'h44, 8'h55, 8'h66, 1'b0);
      for (int k = 1; k <= 16; k++) begin
         step();
         check("to_no_done", done, 1'b0);
         if (k == 15) begin
            check("to_err_early", err, 1'b0);
            check("to_busy_early", busy, 1'b1);
         end
         if (k == 16) begin
            check("to_err", err, 1'b1);
            check("to_busy", busy, 1'b0);
         end
      end
      step();
      check("err_sticky", err, 1'b1);

      // Race: ack__mac arrives in the cycle wdog == TIMEOUT
      do_start();
      feed(8'b0000_0111, 3, 8'h77, 8'h88, 8'h99, 1'b0);
      for (int k = 1; k <= 16; k++) begin
         if (k == 16) mac_force = 1'b1;
         step();
         if (k == 15) check("race_pre_done", done, 1'b0);
      end
      check("race_done", done, 1'b1);
      check("race_err", err, 1'b0);
      mac_force = 1'b0;
      step();
      check("race_done_one", done, 1'b0);
      check("race_idle", busy, 1'b0);

      // Mid-pass reset after the second ack
      use_model = 1'b1;
      do_start();
      feed(8'b0000_0011, 2, 8'h12, 8'h34, 8'h56, 1'b0);
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      step();
      check("midrst_no_done", done, 1'b0);
      rst = 1'b0;
      step(); step();
      check("postrst_idle", busy, 1'b0);
      check("postrst_clr", clr, 1'b0);
      do_start();
      feed(8'b0000_0111, 3, 8'h5A, 8'hA5, 8'h3C, 1'b0);
      wait_done();

      // Spurious start and ack__mac during FEED
      do_start();
      feed(8'b0000_1101, 4, 8'hDE, 8'hAD, 8'hBE, 1'b1);
      wait_done();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: sim time limit reached");
      $fatal(1);
   end

endmodule
